// File: rtl/spi_cmd_seq.sv
// spi_cmd_seq: host command FIFO feeding an SPI master with one command outstanding, read capture, inter-command gap and timeout.
// Ports: clk/rst (async active-high); wr_en/wr_cmd/fifo_full host push side;
// cmd_out/cmd_vld/cmd_rdy SPI master handshake; spi_read_vld/spi_read_data read return;
// rd_vld/rd_addr/rd_data completed read; busy, timeout_err (sticky), err_clr.
module spi_cmd_seq #(
  parameter int CMD_WIDTH  = 12,
  parameter int READ_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [CMD_WIDTH-1:0]  wr_cmd,
  output logic                  fifo_full,
  output logic [CMD_WIDTH-1:0]  cmd_out,
  output logic                  cmd_vld,
  input  logic                  cmd_rdy,
  input  logic                  spi_read_vld,
  input  logic [READ_WIDTH-1:0] spi_read_data,
  output logic                  rd_vld,
  output logic [2:0]            rd_addr,
  output logic [READ_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;
  state_t state, state_n;
  logic [CMD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  logic [10:0] tcnt;
  logic pop, push, is_wr, done, tmo, rd_done;
  assign fifo_full = cnt == (AW+1)'(FIFO_DEPTH);
  assign pop       = state == IDLE && cnt != '0;
  // a pop in the same cycle frees a slot, so a push on a full FIFO is still taken
  assign push      = wr_en && (!fifo_full || pop);
  assign is_wr     = cmd_out[CMD_WIDTH-1];
  // a write's completion ignores cmd_rdy on the first WAIT_DONE cycle (tcnt==0),
  // since the master may not have dropped it yet
  assign done      = is_wr ? (cmd_rdy && tcnt != '0) : spi_read_vld;
  assign tmo       = !done && tcnt == 11'(TIMEOUT - 1);
  assign rd_done   = state == WAIT_DONE && !is_wr && spi_read_vld;
  assign cmd_vld   = state == ISSUE;
  assign busy      = cnt != '0 || state != IDLE;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      state_n = cnt != '0 ? ISSUE : IDLE;
      ISSUE:     state_n = cmd_rdy ? WAIT_DONE : ISSUE;
      WAIT_DONE: state_n = (done || tmo) ? GAP : WAIT_DONE;
      GAP:       state_n = tcnt == 11'(GAP_CYCLES - 1) ? IDLE : GAP;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      wptr        <= '0;
      rptr        <= '0;
      cnt         <= '0;
      cmd_out     <= '0;
      rd_vld      <= 1'b0;
      rd_addr     <= '0;
      rd_data     <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      // one counter serves both WAIT_DONE timeout and GAP length; it restarts on every state change
      tcnt  <= state_n != state ? '0 : tcnt + 1'b1;
      if (push) begin
        mem[wptr] <= wr_cmd;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        cmd_out <= mem[rptr];
        rptr    <= rptr + 1'b1;
      end
      cnt    <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      rd_vld <= rd_done;
      if (rd_done) begin
        rd_addr <= cmd_out[CMD_WIDTH-2 -: 3];
        rd_data <= spi_read_data;
      end
      // set wins over a simultaneous clear
      timeout_err <= (state == WAIT_DONE && tmo) || (timeout_err && !err_clr);
    end
  end
endmodule

// File: tb/tb_spi_cmd_seq.sv
module tb_spi_cmd_seq;
  localparam int GAP = 4, TMO = 1023, DEPTH = 4;
  logic clk = 0, rst = 1, wr_en = 0, cmd_rdy = 0, spi_read_vld = 0, err_clr = 0;
  logic [11:0] wr_cmd = 0;
  logic [7:0] spi_read_data = 0;
  logic fifo_full, cmd_vld, rd_vld, busy, timeout_err;
  logic [11:0] cmd_out;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  int total = 0, bad = 0, vld_cnt = 0, rd_cnt = 0;
  logic [11:0] issued[$];
  bit chk_on = 0;

  spi_cmd_seq dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_cmd(wr_cmd), .fifo_full(fifo_full),
    .cmd_out(cmd_out), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .spi_read_vld(spi_read_vld),
    .spi_read_data(spi_read_data), .rd_vld(rd_vld), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // Reference model: a queue for the FIFO, one in-flight transaction record, and the
  // edge index at which the post-command gap ends. Evaluated on each clock edge from the
  // inputs that edge sees.
  logic [11:0] m_q[$];
  bit m_have, m_acc, m_pop, m_tmo, m_e_rdv, m_e_err;
  logic [11:0] m_cur, m_e_cmd;
  logic [2:0] m_e_addr;
  logic [7:0] m_e_data;
  int m_n = 0, m_gap_end = -1, m_w = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_have = 0; m_acc = 0; m_n = 0; m_gap_end = -1; m_w = 0;
      m_e_cmd = 0; m_e_rdv = 0; m_e_addr = 0; m_e_data = 0; m_e_err = 0;
    end else begin
      m_pop = 0; m_tmo = 0; m_e_rdv = 0;
      if (!m_have) begin
        if (m_n - 1 >= m_gap_end && m_q.size() > 0) begin
          m_pop = 1; m_cur = m_q.pop_front(); m_have = 1; m_acc = 0; m_e_cmd = m_cur;
        end
      end else if (!m_acc) begin
        if (cmd_rdy) begin m_acc = 1; m_w = 0; end
      end else if (m_cur[11] ? (cmd_rdy && m_w > 0) : spi_read_vld) begin
        if (!m_cur[11]) begin m_e_rdv = 1; m_e_addr = m_cur[10:8]; m_e_data = spi_read_data; end
        m_have = 0; m_gap_end = m_n + GAP;
      end else if (m_w == TMO - 1) begin
        m_tmo = 1; m_have = 0; m_gap_end = m_n + GAP;
      end else m_w++;
      if (wr_en && m_q.size() < DEPTH) m_q.push_back(wr_cmd);
      m_e_err = m_tmo ? 1'b1 : (err_clr ? 1'b0 : m_e_err);
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmd_vld", cmd_vld, m_have && !m_acc);
      chk("cmd_out", cmd_out, m_e_cmd);
      chk("fifo_full", fifo_full, m_q.size() == DEPTH);
      chk("busy", busy, m_q.size() > 0 || m_have || (m_n - 1) < m_gap_end);
      chk("rd_vld", rd_vld, m_e_rdv);
      chk("timeout_err", timeout_err, m_e_err);
      if (m_e_rdv) begin
        chk("rd_addr", rd_addr, m_e_addr);
        chk("rd_data", rd_data, m_e_data);
      end
    end
    if (cmd_vld) vld_cnt++;
    if (cmd_vld && cmd_rdy) issued.push_back(cmd_out);
    if (rd_vld) rd_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [11:0] v[5];
    v = '{12'h811, 12'h822, 12'h833, 12'h844, 12'h855};
    step; step;
    @(negedge clk);
    chk("rst_cmd_out", cmd_out, 0);
    chk("rst_cmd_vld", cmd_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", fifo_full, 0);
    step;
    rst = 0;
    chk_on = 1;
    // single write with a long transfer
    vld_cnt = 0; cmd_rdy = 1; wr_en = 1; wr_cmd = 12'h8A5;
    step;
    wr_en = 0;
    for (int i = 0; i < 20 && !cmd_vld; i++) @(negedge clk);
    chk("t1_vld", cmd_vld, 1);
    chk("t1_cmd", cmd_out, 12'h8A5);
    step;
    cmd_rdy = 0;
    repeat (12) step;
    cmd_rdy = 1;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin n++; @(negedge clk); end
    chk("t1_tail", n, 5);
    chk("t1_vld_cycles", vld_cnt, 1);
    // single read
    wr_en = 1; wr_cmd = 12'h300;
    step;
    wr_en = 0;
    for (int i = 0; i < 20 && !cmd_vld; i++) @(negedge clk);
    chk("t2_vld", cmd_vld, 1);
    step; step;
    spi_read_vld = 1; spi_read_data = 8'h5C;
    step;
    spi_read_vld = 0;
    @(negedge clk);
    chk("t2_rd_vld", rd_vld, 1);
    chk("t2_rd_addr", rd_addr, 3);
    chk("t2_rd_data", rd_data, 8'h5C);
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    // stalled master, overfill the FIFO
    issued.delete(); cmd_rdy = 0; wr_en = 1; wr_cmd = 12'h801;
    step;
    wr_en = 0;
    for (int i = 0; i < 20 && !cmd_vld; i++) @(negedge clk);
    step;
    for (int i = 0; i < 5; i++) begin wr_en = 1; wr_cmd = v[i]; step; end
    wr_en = 0;
    @(negedge clk);
    chk("t3_full", fifo_full, 1);
    step;
    cmd_rdy = 1;
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    chk("t3_count", issued.size(), 5);
    if (issued.size() == 5) begin
      chk("t3_first", issued[0], 12'h801);
      for (int i = 0; i < 4; i++) chk("t3_order", issued[i+1], v[i]);
    end
    // read that never returns
    wr_en = 1; wr_cmd = 12'h200;
    step;
    wr_en = 0;
    for (int i = 0; i < 20 && !cmd_vld; i++) @(negedge clk);
    rd_cnt = 0; n = 0;
    while (!timeout_err && n < 1200) begin @(negedge clk); n++; end
    chk("t4_latency", n, 1024);
    chk("t4_no_rd", rd_cnt, 0);
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    chk("t4_sticky", timeout_err, 1);
    step;
    err_clr = 1;
    step;
    err_clr = 0;
    @(negedge clk);
    chk("t4_clr", timeout_err, 0);
    // reset mid-transaction with two entries queued
    wr_en = 1; wr_cmd = 12'h100;
    step;
    wr_en = 0;
    for (int i = 0; i < 20 && !cmd_vld; i++) @(negedge clk);
    step;
    wr_en = 1; wr_cmd = 12'h8AA;
    step;
    wr_cmd = 12'h8BB;
    step;
    wr_en = 0;
    step;
    rst = 1;
    @(negedge clk);
    chk("t5_cmd_vld", cmd_vld, 0);
    chk("t5_cmd_out", cmd_out, 0);
    chk("t5_rd_vld", rd_vld, 0);
    chk("t5_rd_addr", rd_addr, 0);
    chk("t5_rd_data", rd_data, 0);
    chk("t5_err", timeout_err, 0);
    chk("t5_busy", busy, 0);
    chk("t5_full", fifo_full, 0);
    step;
    rst = 0; vld_cnt = 0; rd_cnt = 0;
    for (int i = 0; i < 20; i++) begin spi_read_vld = i[0]; spi_read_data = 8'($urandom); step; end
    spi_read_vld = 0;
    @(negedge clk);
    chk("t5_no_issue", vld_cnt, 0);
    chk("t5_no_rd", rd_cnt, 0);
    chk("t5_idle", busy, 0);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      wr_en = $urandom_range(0, 3) == 0;
      wr_cmd = 12'($urandom);
      cmd_rdy = $urandom_range(0, 3) != 0;
      spi_read_vld = $urandom_range(0, 7) == 0;
      spi_read_data = 8'($urandom);
      err_clr = $urandom_range(0, 49) == 0;
      rst = $urandom_range(0, 799) == 0;
      step;
    end
    rst = 0; wr_en = 0; err_clr = 0; spi_read_vld = 0;
    step;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_cmd_seq.md
SPI_CMD_SEQ -- requirements
Module: spi_cmd_seq

Interface
REQ-001 SHALL have parameter CMD_WIDTH, default 12, command word width; bit 11 is W/R (1=write, 0=read), bits 10:8 are address, bits 7:0 are write data.
REQ-002 SHALL have parameter READ_WIDTH, default 8, read data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries, power of two.
REQ-004 SHALL have parameter GAP_CYCLES, default 4, idle clocks between consecutive SPI commands.
REQ-005 SHALL have parameter TIMEOUT, default 1023, max clocks to wait for SPI completion.
REQ-006 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port wr_en  in  1  host push of wr_cmd into FIFO.
REQ-009 SHALL have port wr_cmd  in  CMD_WIDTH  host command word.
REQ-010 SHALL have port fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-011 SHALL have port cmd_out  out  CMD_WIDTH  command to SPI master.
REQ-012 SHALL have port cmd_vld  out  1  cmd_out valid.
REQ-013 SHALL have port cmd_rdy  in  1  SPI master ready; low while a transfer is in progress.
REQ-014 SHALL have port spi_read_vld  in  1  one-cycle pulse, SPI read data valid.
REQ-015 SHALL have port spi_read_data  in  READ_WIDTH  SPI read data.
REQ-016 SHALL have port rd_vld  out  1  one-cycle pulse, read result valid.
REQ-017 SHALL have port rd_addr  out  3  address of the completed read.
REQ-018 SHALL have port rd_data  out  READ_WIDTH  completed read data.
REQ-019 SHALL have port busy  out  1  FIFO non-empty or FSM not IDLE.
REQ-020 SHALL have port timeout_err  out  1  sticky timeout flag.
REQ-021 SHALL have port err_clr  in  1  clears timeout_err.

Function
REQ-022 SHALL implement a FIFO_DEPTH-entry FIFO with wrapping read/write pointers plus an occupancy counter; wr_en while fifo_full is dropped with no state change.
REQ-023 SHALL handle a simultaneous push and pop on a full FIFO by accepting both, leaving occupancy unchanged.
REQ-024 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE, GAP.
REQ-025 SHALL transition IDLE->ISSUE when the FIFO is non-empty, loading the head entry into cmd_out and popping it.
REQ-026 SHALL hold cmd_vld=1 and cmd_out stable in ISSUE until a cycle with cmd_vld&&cmd_rdy, then go to WAIT_DONE next cycle with cmd_vld=0.
REQ-027 SHALL, in WAIT_DONE for a write, ignore cmd_rdy in the first cycle and complete on the first subsequent cycle with cmd_rdy=1.
REQ-028 SHALL, in WAIT_DONE for a read, complete on spi_read_vld and assert rd_vld for one cycle on the next clock, with rd_data=spi_read_data and rd_addr=cmd_out[10:8].
REQ-029 SHALL ignore spi_read_vld outside WAIT_DONE-for-read.
REQ-030 SHALL count WAIT_DONE cycles in an 11-bit counter; on reaching TIMEOUT it SHALL set timeout_err, emit no rd_vld, and go to GAP.
REQ-031 SHALL stay in GAP exactly GAP_CYCLES clocks, then return to IDLE; the next ISSUE occurs no earlier than the cycle after.
REQ-032 SHALL latch timeout_err until err_clr; a set and clear in the same cycle resolves to set.
REQ-033 SHALL never have more than one command outstanding to the SPI master.

Reset
REQ-034 SHALL, on rst, asynchronously clear FIFO contents and pointers, enter IDLE, and drive cmd_out=0, cmd_vld=0, rd_vld=0, rd_addr=0, rd_data=0, timeout_err=0, busy=0, fifo_full=0.
REQ-035 SHALL, on rst asserted mid-transaction, abandon the command; no rd_vld is generated after release.

Verification
REQ-036 SHALL cover: push write 0x8A5, cmd_rdy=1 -> cmd_vld 1 cycle, cmd_out=0x8A5, after cmd_rdy low 12 cycles then high -> GAP 4 cycles -> IDLE, busy=0.
REQ-037 SHALL cover: push read 0x300, spi_read_vld with data 0x5C -> next cycle rd_vld=1, rd_addr=3, rd_data=0x5C.
REQ-038 SHALL cover: push 5 commands back-to-back with FSM stalled (cmd_rdy=0) -> fifo_full after 4 accepted, 5th dropped, 4 commands issued in order.
REQ-039 SHALL cover: read with spi_read_vld never asserted -> timeout_err=1 after 1023 WAIT_DONE cycles, no rd_vld, err_clr clears it.
REQ-040 SHALL cover: rst asserted during WAIT_DONE with 2 entries queued -> all outputs at reset values, no command issued after release until a new push.
